// File: rtl/link_arbiter_pkg.sv
// link_arbiter_pkg: shared packet type, arbiter states and packet size for the link arbiter
package link_arbiter_pkg;
  localparam int PKT_BYTES = 4;
  typedef logic [8*PKT_BYTES-1:0] pkt_t;
  typedef enum logic [1:0] {IDLE, WAIT_FREE, SEND} arb_state_t;
endpackage

// File: rtl/link_arbiter_rr_picker.sv
// rr_picker: combinational round-robin picker, first valid request after the last grant wins
module rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [W-1:0]       last_i,
  output logic [W-1:0]       winner_o,
  output logic               any_valid_o
);
  // scan from farthest to nearest offset so the nearest valid index after last_i is kept
  always_comb begin
    winner_o = last_i;
    any_valid_o = |req_i;
    for (int i = NUM_REQ; i >= 1; i--)
      if (req_i[(int'(last_i) + i) % NUM_REQ]) winner_o = W'((int'(last_i) + i) % NUM_REQ);
  end
endmodule

// File: rtl/link_arbiter.sv
// link_arbiter: round-robin arbiter serializing 32-bit packets MSB first onto a put/free byte link; LINK_ARB_STATS_EN adds per-requester grant counters
module link_arbiter
  import link_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PKT_BYTES = 4,
  localparam int W = $clog2(NUM_REQ),
  localparam int CW = $clog2(PKT_BYTES)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  pkt_t [NUM_REQ-1:0]       req_pkt,
  output logic [NUM_REQ-1:0]       req_ack,
  input  logic                     free_outbound,
  output logic                     put_outbound,
  output logic [7:0]               payload_outbound,
  output logic [W-1:0]             grant_id,
`ifdef LINK_ARB_STATS_EN
  input  logic                     stats_clr,
  output logic [NUM_REQ-1:0][15:0] grant_count,
`endif
  output logic                     busy
);
  arb_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  pkt_t buf_q, buf_d;
  logic [W-1:0] grant_q, grant_d, winner;
  logic put_q, put_d, any_valid;
  logic [7:0] payload_q, payload_d;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i(req_valid),
    .last_i(grant_q),
    .winner_o(winner),
    .any_valid_o(any_valid)
  );

  // next state, capture on ack, and next registered link byte derived from the next state
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    buf_d = buf_q;
    grant_d = grant_q;
    req_ack = '0;
    unique case (state_q)
      IDLE: if (any_valid) begin
        req_ack[winner] = 1'b1;
        buf_d = req_pkt[winner];
        grant_d = winner;
        state_d = WAIT_FREE;
      end
      WAIT_FREE: if (free_outbound) begin
        state_d = SEND;
        cnt_d = '0;
      end
      SEND: begin
        state_d = (cnt_q == CW'(PKT_BYTES - 1)) ? IDLE : SEND;
        cnt_d = (cnt_q == CW'(PKT_BYTES - 1)) ? '0 : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    put_d = (state_d == SEND);
    payload_d = put_d ? 8'(buf_d >> (8 * (PKT_BYTES - 1 - int'(cnt_d)))) : 8'h00;
  end

  // state, packet buffer and registered link outputs
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      buf_q <= '0;
      grant_q <= W'(NUM_REQ - 1);
      put_q <= 1'b0;
      payload_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      buf_q <= buf_d;
      grant_q <= grant_d;
      put_q <= put_d;
      payload_q <= payload_d;
    end

  assign put_outbound = put_q;
  assign payload_outbound = payload_q;
  assign grant_id = grant_q;
  assign busy = (state_q != IDLE);

`ifdef LINK_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] count_q, count_d;

  // saturating per-requester ack counters; clear beats a same-cycle increment
  always_comb begin
    count_d = count_q;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ack[i] && count_q[i] != 16'hFFFF) count_d[i] = count_q[i] + 16'd1;
    if (stats_clr) count_d = '0;
  end

  // grant counter registers
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) count_q <= '0;
    else count_q <= count_d;

  assign grant_count = count_q;
`endif
endmodule

// File: tb/tb_link_arbiter.sv
// tb_link_arbiter: randomized self-checking bench for link_arbiter against a transaction-level model; LINK_ARB_STATS_EN enables counter checks
module tb_link_arbiter;
  import link_arbiter_pkg::*;
  localparam int N = 4;
  logic clock = 1'b0;
  logic reset_n;
  logic [N-1:0] req_valid;
  pkt_t [N-1:0] req_pkt;
  logic [N-1:0] req_ack;
  logic free_outbound;
  logic put_outbound;
  logic [7:0] payload_outbound;
  logic [1:0] grant_id;
  logic busy;
  int checks = 0;
  int errors = 0;
  int last = N - 1;
`ifdef LINK_ARB_STATS_EN
  logic stats_clr;
  logic [N-1:0][15:0] grant_count;
  int cnt_m [N];
`endif

  link_arbiter #(.NUM_REQ(N), .PKT_BYTES(4)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_pkt(req_pkt),
    .req_ack(req_ack),
    .free_outbound(free_outbound),
    .put_outbound(put_outbound),
    .payload_outbound(payload_outbound),
    .grant_id(grant_id),
`ifdef LINK_ARB_STATS_EN
    .stats_clr(stats_clr),
    .grant_count(grant_count),
`endif
    .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic int pick(input logic [N-1:0] v, input int from);
    for (int i = 1; i <= N; i++) if (v[(from + i) % N]) return (from + i) % N;
    return from;
  endfunction

  task automatic model_reset();
    last = N - 1;
`ifdef LINK_ARB_STATS_EN
    for (int i = 0; i < N; i++) cnt_m[i] = 0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    req_valid = '0;
    free_outbound = 1'b0;
`ifdef LINK_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // one packet: ack cycle, k cycles with free low, then 4 SEND bytes; abort_at>=0 resets during that byte
  task automatic xfer(input logic [N-1:0] v, input int k, input bit keep, input int abort_at, input pkt_t fixed, input bit clr);
    int w;
    pkt_t p;
    logic [N-1:0] e;
    w = pick(v, last);
    req_valid = v;
    for (int i = 0; i < N; i++) req_pkt[i] = $urandom;
    if (fixed != '0) req_pkt[w] = fixed;
    p = req_pkt[w];
    free_outbound = 1'($urandom);
`ifdef LINK_ARB_STATS_EN
    stats_clr = clr;
`endif
    e = '0;
    e[w] = 1'b1;
    #1;
    checks++; if (req_ack !== e) begin errors++; $display("FAIL ack_pulse got %b expected %b", req_ack, e); end
    checks++; if (busy !== 1'b0 || put_outbound !== 1'b0) begin errors++; $display("FAIL idle_outputs busy %b put %b expected 0 0", busy, put_outbound); end
    @(posedge clock);
    last = w;
`ifdef LINK_ARB_STATS_EN
    if (clr) for (int i = 0; i < N; i++) cnt_m[i] = 0;
    else if (cnt_m[w] < 65535) cnt_m[w]++;
`endif
    @(negedge clock);
`ifdef LINK_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    if (!keep) req_valid = N'($urandom);
    for (int i = 0; i < N; i++) req_pkt[i] = $urandom;
    free_outbound = (k == 0);
    #1;
    checks++; if (req_ack !== '0 || busy !== 1'b1 || put_outbound !== 1'b0) begin errors++; $display("FAIL wait_first ack %b busy %b put %b expected 0 1 0", req_ack, busy, put_outbound); end
    checks++; if (grant_id !== 2'(w)) begin errors++; $display("FAIL grant_id got %0d expected %0d", grant_id, w); end
    for (int j = 0; j < k; j++) begin
      @(negedge clock);
      free_outbound = (j == k - 1);
      #1;
      checks++; if (put_outbound !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wait_free put %b busy %b expected 0 1", put_outbound, busy); end
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clock);
      if (b == abort_at) begin
        reset_n = 1'b0;
        #1;
        checks++; if (put_outbound !== 1'b0 || payload_outbound !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL async_reset put %b payload %h busy %b expected 0 00 0", put_outbound, payload_outbound, busy); end
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        return;
      end
      free_outbound = 1'($urandom);
      if (!keep) req_valid = N'($urandom);
      #1;
      checks++; if (put_outbound !== 1'b1 || payload_outbound !== p[8*(3-b) +: 8]) begin errors++; $display("FAIL send_byte%0d put %b payload %h expected 1 %h", b, put_outbound, payload_outbound, p[8*(3-b) +: 8]); end
      checks++; if (req_ack !== '0 || busy !== 1'b1) begin errors++; $display("FAIL send_state ack %b busy %b expected 0 1", req_ack, busy); end
    end
    @(negedge clock);
    req_valid = '0;
    #1;
    checks++; if (put_outbound !== 1'b0 || payload_outbound !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL after_send put %b payload %h busy %b expected 0 00 0", put_outbound, payload_outbound, busy); end
`ifdef LINK_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      checks++; if (grant_count[i] !== 16'(cnt_m[i])) begin errors++; $display("FAIL grant_count%0d got %0d expected %0d", i, grant_count[i], cnt_m[i]); end
    end
`endif
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (put_outbound !== 1'b0 || payload_outbound !== 8'h00 || busy !== 1'b0 || req_ack !== '0) begin errors++; $display("FAIL reset_outputs put %b payload %h busy %b ack %b expected 0 00 0 0", put_outbound, payload_outbound, busy, req_ack); end
    checks++; if (grant_id !== 2'(N - 1)) begin errors++; $display("FAIL reset_grant got %0d expected %0d", grant_id, N - 1); end
  endtask

  task automatic test_single();
    do_reset();
    xfer(4'b0001, 0, 1'b0, -1, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_all_valid();
    do_reset();
    for (int t = 0; t < 5; t++) xfer(4'b1111, 0, 1'b1, -1, '0, 1'b0);
  endtask

  task automatic test_wait_free();
    xfer(4'b0010, 10, 1'b0, -1, '0, 1'b0);
  endtask

  task automatic test_wrap();
    do_reset();
    xfer(4'b0100, 1, 1'b0, -1, '0, 1'b0);
    xfer(4'b0101, 0, 1'b1, -1, '0, 1'b0);
    xfer(4'b0101, 2, 1'b1, -1, '0, 1'b0);
  endtask

  task automatic test_reset_mid_send();
    xfer(4'b1000, 0, 1'b0, 2, '0, 1'b0);
    #1;
    checks++; if (grant_id !== 2'(N - 1) || busy !== 1'b0) begin errors++; $display("FAIL post_abort grant %0d busy %b expected %0d 0", grant_id, busy, N - 1); end
    xfer(4'b1000, 0, 1'b0, -1, '0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      logic [N-1:0] v;
      v = N'($urandom_range(1, (1 << N) - 1));
      xfer(v, $urandom_range(0, 3), 1'($urandom), -1, '0, 1'b0);
    end
  endtask

`ifdef LINK_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int t = 0; t < 3; t++) xfer(4'b0010, 0, 1'b0, -1, '0, 1'b0);
    xfer(4'b0010, 0, 1'b0, -1, '0, 1'b1);
  endtask
`endif

  initial begin
    reset_n = 1'b1;
    req_valid = '0;
    req_pkt = '0;
    free_outbound = 1'b0;
`ifdef LINK_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_single();
    test_all_valid();
    test_wait_free();
    test_wrap();
    test_reset_mid_send();
    test_random();
`ifdef LINK_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
